// File: rtl/aes_decipher_iter.sv
// aes_decipher_iter: iterative AES-128 inverse cipher, one round per clock.
// The block takes a ciphertext and the original cipher key. It first walks the
// forward key schedule up to rk10. It then runs ten inverse rounds and walks the
// key schedule backwards at the same time, so only one key-step unit is needed
// in each direction.
// function_index selects the round variant. 0 is standard FIPS-197. 1 is the
// custom variant, in which the encrypt side rotates row r RIGHT by r in ShiftRows,
// so this side rotates row r LEFT by r in its inverse.
// Optional build macro AES_DEC_KEY_CACHE_EN adds a one-entry rk10 cache. When the
// incoming key matches the cached key, the forward key expansion is skipped.
module aes_decipher_iter #(
  parameter int NUM_ROUNDS   = 10,
  parameter bit CLEAR_ON_POP = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_function_index,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_datain,
  input  logic [127:0] i_key,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_dataout,
  output logic         o_busy
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  // Only AES-128 (ten rounds) is meaningful; the count ends at NUM_ROUNDS-1.
  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Byte n of a block; byte 0 sits in bits [127:120].
  function automatic logic [7:0] getByte(input logic [127:0] s, input logic [3:0] n);
    return s[{~n, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (0x9, 0xb, 0xd, 0xe for InvMixColumns).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? a : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0: r = 8'h01;
      4'd1: r = 8'h02;
      4'd2: r = 8'h04;
      4'd3: r = 8'h08;
      4'd4: r = 8'h10;
      4'd5: r = 8'h20;
      4'd6: r = 8'h40;
      4'd7: r = 8'h80;
      4'd8: r = 8'h1b;
      4'd9: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Output byte (row r, col c) takes input column c-r (standard) or c+r (variant 1).
  function automatic logic [127:0] invShiftRows(input logic [127:0] s, input logic fi);
    logic [127:0] o;
    logic [3:0]   n;
    logic [1:0]   srcCol;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      n      = 4'(i);
      srcCol = fi ? (n[3:2] + n[1:0]) : (n[3:2] - n[1:0]);
      o      = {o[119:0], getByte(s, {srcCol, n[1:0]})};
    end
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o = {o[119:0], invSbox(getByte(s, 4'(i)))};
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = getByte(s, 4'(4 * c));
      a1 = getByte(s, 4'(4 * c + 1));
      a2 = getByte(s, 4'(4 * c + 2));
      a3 = getByte(s, 4'(4 * c + 3));
      o  = {o[95:0],
            gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    end
    return o;
  endfunction

  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // rk(i) -> rk(i+1)
  function automatic logic [127:0] keyStepFwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // rk(i) -> rk(i-1); the last word is recovered first because it feeds SubWord.
  function automatic logic [127:0] keyStepInv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ subRotWord(p3) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  state_t       r_fsm, w_fsmNext;
  logic         r_inReady;
  logic [3:0]   r_cnt;
  logic         r_fi;
  logic [127:0] r_block;
  logic [127:0] r_rk;
  logic         r_outValid;
  logic [127:0] r_dataout;

  logic         w_accept;
  logic         w_cacheHit;
  logic [127:0] w_cachedRk10;
  logic [127:0] w_rkFwd;
  logic [127:0] w_rkInv;
  logic [127:0] w_roundPre;
  logic [127:0] w_roundOut;

  assign w_accept   = i_in_valid & r_inReady;
  assign w_rkFwd    = keyStepFwd(r_rk, rcon(r_cnt));
  assign w_rkInv    = keyStepInv(r_rk, rcon(LAST_CNT - r_cnt));
  assign w_roundPre = invSubBytes(invShiftRows(r_block, r_fi)) ^ w_rkInv;
  assign w_roundOut = invMixColumns(w_roundPre);

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_latchedKey;
  logic [127:0] r_cachedKey;
  logic [127:0] r_cachedRk10;
  logic         r_cacheVld;

  assign w_cacheHit   = r_cacheVld && (i_key == r_cachedKey);
  assign w_cachedRk10 = r_cachedRk10;

  // Remember the key of each request and capture rk10 when its expansion finishes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_latchedKey <= '0;
      r_cachedKey  <= '0;
      r_cachedRk10 <= '0;
      r_cacheVld   <= 1'b0;
    end else if (r_fsm == IDLE && w_accept) begin
      r_latchedKey <= i_key;
    end else if (r_fsm == KEXP && r_cnt == LAST_CNT) begin
      r_cachedKey  <= r_latchedKey;
      r_cachedRk10 <= w_rkFwd;
      r_cacheVld   <= 1'b1;
    end
  end
`else
  assign w_cacheHit   = 1'b0;
  assign w_cachedRk10 = '0;
`endif

  // Control state register. in_ready is registered so that it stays low during reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm     <= IDLE;
      r_inReady <= 1'b0;
    end else begin
      r_fsm     <= w_fsmNext;
      r_inReady <= (w_fsmNext == IDLE);
    end
  end

  // Next-state selection for the IDLE -> KEXP -> ROUND -> DONE sequence.
  always_comb begin
    w_fsmNext = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsmNext = w_cacheHit ? ROUND : KEXP;
      KEXP:    if (r_cnt == LAST_CNT) w_fsmNext = ROUND;
      ROUND:   if (r_cnt == LAST_CNT) w_fsmNext = DONE;
      DONE:    if (i_out_ready) w_fsmNext = IDLE;
      default: w_fsmNext = IDLE;
    endcase
  end

  // Datapath: latch the request, expand the key forward, then run the inverse rounds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_fi       <= 1'b0;
      r_block    <= '0;
      r_rk       <= '0;
      r_outValid <= 1'b0;
      r_dataout  <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_fi  <= i_function_index;
            r_cnt <= '0;
            if (w_cacheHit) begin
              r_block <= i_datain ^ w_cachedRk10;
              r_rk    <= w_cachedRk10;
            end else begin
              r_block <= i_datain;
              r_rk    <= i_key;
            end
          end
        end
        KEXP: begin
          r_rk <= w_rkFwd;
          if (r_cnt == LAST_CNT) begin
            r_block <= r_block ^ w_rkFwd;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ROUND: begin
          r_rk <= w_rkInv;
          if (r_cnt == LAST_CNT) begin
            r_dataout  <= w_roundPre;
            r_outValid <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_block <= w_roundOut;
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_outValid <= 1'b0;
            if (CLEAR_ON_POP) r_dataout <= '0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_in_ready  = r_inReady;
  assign o_out_valid = r_outValid;
  assign o_dataout   = r_dataout;
  assign o_busy      = (r_fsm == KEXP) || (r_fsm == ROUND);

endmodule

// File: tb/tb_aes_decipher_iter.sv
// tb_aes_decipher_iter: self-checking bench for aes_decipher_iter.
// The reference model is a plain forward AES-128 encryptor. Its S-box is built
// from the GF(2^8) generator walk. Round-trip cases encrypt random plaintext in
// the model and expect the DUT to return the original plaintext. Expected
// latency follows a one-entry key-cache model when the design is built with
// AES_DEC_KEY_CACHE_EN.
module tb_aes_decipher_iter;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CacheBuilt = 1'b1;
`else
  localparam bit CacheBuilt = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         fi;
  logic         inValid;
  logic         inReady;
  logic [127:0] datain;
  logic [127:0] keyIn;
  logic         outValid;
  logic         outReady;
  logic [127:0] dataout;
  logic         busy;

  int           testCount = 0;
  int           failCount = 0;
  int           expLat;
  logic         cacheVld = 1'b0;
  logic [127:0] cacheKey = '0;
  logic [7:0]   sboxTab [256];

  aes_decipher_iter #(.NUM_ROUNDS(10), .CLEAR_ON_POP(1'b1)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_function_index (fi),
    .i_in_valid       (inValid),
    .o_in_ready       (inReady),
    .i_datain         (datain),
    .i_key            (keyIn),
    .o_out_valid      (outValid),
    .i_out_ready      (outReady),
    .o_dataout        (dataout),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < s; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Walk the multiplicative group with generator 3 while tracking its inverse.
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sboxTab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTab[0] = 8'h63;
  endtask

  // Forward AES-128. With fi=1, ShiftRows rotates row r right by r.
  function automatic logic [127:0] modelEncrypt(input logic [127:0] pt, input logic [127:0] k,
                                                input logic f);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    int           sh;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]], sboxTab[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gfMul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (120 - 8 * i)) ^ 8'(w[i/4] >> (24 - 8 * (i % 4)));
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxTab[s[i]];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          sh = f ? (4 - row) : row;
          t[4*c+row] = s[4*((c + sh) % 4) + row];
        end
      end
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gfMul(a0, 8'h02) ^ gfMul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gfMul(a1, 8'h02) ^ gfMul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gfMul(a2, 8'h02) ^ gfMul(a3, 8'h03);
          s[4*c+3] = gfMul(a0, 8'h03) ^ a1 ^ a2 ^ gfMul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ 8'(w[4*r + i/4] >> (24 - 8 * (i % 4)));
    end
    res = '0;
    for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one request and return #1 after its accept edge.
  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] k, input logic f);
    int guard;
    guard = 0;
    @(negedge clk);
    while (inReady !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkValue("inReadyBeforeAccept", int'(inReady), 1);
    expLat   = (CacheBuilt && cacheVld && k == cacheKey) ? 10 : 20;
    cacheVld = 1'b1;
    cacheKey = k;
    datain   = ct;
    keyIn    = k;
    fi       = f;
    inValid  = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkValue("busyAfterAccept", int'(busy), 1);
  endtask

  // Count edges to out_valid. Optionally pulse in_valid with junk from edge pulseAt.
  task automatic waitResult(input int pulseAt, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (pulseAt > 0 && k == pulseAt) begin
        datain  = {$urandom, $urandom, $urandom, $urandom};
        keyIn   = {$urandom, $urandom, $urandom, $urandom};
        fi      = ~fi;
        inValid = 1'b1;
      end
      if (pulseAt > 0 && k == pulseAt + 3) inValid = 1'b0;
      if (outValid === 1'b1) begin
        lat = k;
        break;
      end
    end
    inValid = 1'b0;
  endtask

  task automatic popOutput();
    @(negedge clk);
    outReady = 1'b1;
    checkValue("inReadyLowInDone", int'(inReady), 0);
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkValue("outValidAfterPop", int'(outValid), 0);
    checkOutput("dataoutClearedAfterPop", dataout, '0);
    checkValue("inReadyAfterPop", int'(inReady), 1);
  endtask

  initial begin
    int           lat;
    logic [127:0] pt, k, ct;
    logic         f;

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    datain   = '0;
    keyIn    = '0;
    fi       = 1'b0;
    buildSbox();

    // Reset values while rst is held high.
    #2;
    checkValue("resetInReady", int'(inReady), 0);
    checkValue("resetOutValid", int'(outValid), 0);
    checkValue("resetBusy", int'(busy), 0);
    checkOutput("resetDataout", dataout, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkValue("inReadyBeforeFirstEdge", int'(inReady), 0);
    @(posedge clk);
    #1;
    checkValue("inReadyFirstEdge", int'(inReady), 1);

    // Known-answer vector, then hold the result under backpressure.
    applyStimulus(FipsCt, FipsKey, 1'b0);
    waitResult(0, lat);
    checkValue("fipsLatency", lat, expLat);
    checkValue("busyInDone", int'(busy), 0);
    checkOutput("fipsData", dataout, FipsPt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkValue("bpOutValid", int'(outValid), 1);
      checkOutput("bpDataout", dataout, FipsPt);
      checkValue("bpInReady", int'(inReady), 0);
    end
    popOutput();

    // Junk on in_valid during ROUND must not disturb the result.
    applyStimulus(FipsCt, FipsKey, 1'b0);
    waitResult((expLat == 20 ? 10 : 0) + 2, lat);
    checkValue("ignoreLatency", lat, expLat);
    checkOutput("ignoreData", dataout, FipsPt);
    popOutput();

    // Back-to-back repeat of the same key.
    applyStimulus(FipsCt, FipsKey, 1'b0);
    waitResult(0, lat);
    checkValue("repeatLatency", lat, expLat);
    checkOutput("repeatData", dataout, FipsPt);
    popOutput();

    // Different key (FIPS key with bit 0 flipped).
    k  = FipsKey ^ 128'h1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(modelEncrypt(pt, k, 1'b0), k, 1'b0);
    waitResult(0, lat);
    checkValue("otherKeyLatency", lat, expLat);
    checkOutput("otherKeyData", dataout, pt);
    popOutput();

    // Reset in ROUND with cnt=4 aborts the operation without output.
    applyStimulus(FipsCt, FipsKey, 1'b0);
    repeat ((expLat == 20 ? 10 : 0) + 4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkValue("abortInReady", int'(inReady), 0);
    checkValue("abortOutValid", int'(outValid), 0);
    checkValue("abortBusy", int'(busy), 0);
    checkOutput("abortDataout", dataout, '0);
    cacheVld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("abortNoStaleOutput", int'(outValid), 0);

    // Clean restart after the abort.
    applyStimulus(FipsCt, FipsKey, 1'b0);
    waitResult(0, lat);
    checkValue("restartLatency", lat, expLat);
    checkOutput("restartData", dataout, FipsPt);
    popOutput();

    // Random round trips through the reference encryptor, both variants.
    for (int n = 0; n < 40; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      f  = n[0];
      ct = modelEncrypt(pt, k, f);
      applyStimulus(ct, k, f);
      waitResult(0, lat);
      checkValue("randLatency", lat, expLat);
      checkOutput(f ? "randDataFi1" : "randDataFi0", dataout, pt);
      popOutput();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
